// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between a command source and the
// PS/2 host transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, then
// shifts a command byte out on the device-generated clock and checks the ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int MAX_COUNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic [9:0]    shift, shift_n;
  logic          clk_oe_q, clk_oe_n;
  logic          data_oe_q, data_oe_n;
  logic          done_q, done_n;
  logic          error_q, error_n;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          clk_s, data_s, fall, timed;

  // Pins idle high, so the synchronisers reset to 1 to avoid a phantom fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_prev & ~clk_s;
  assign timed  = (state == REQ) || (state == BITS) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      done_q    <= done_n;
      error_q   <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    error_n   = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        cnt_n     = '0;
        if (host.tx_valid) begin
          shift_n  = {1'b1, ~^host.tx_data, host.tx_data};
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          cnt_n     = '0;
          state_n   = REQ;
        end
      end
      REQ: begin
        cnt_n   = cnt + 1'b1;
        idx_n   = '0;
        state_n = BITS;
      end
      BITS: begin
        cnt_n = cnt + 1'b1;
        // Index 9 is the stop bit (1), so its fall releases the data line.
        if (fall) begin
          data_oe_n = ~shift[idx];
          idx_n     = idx + 4'd1;
          if (idx == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        cnt_n = cnt + 1'b1;
        if (fall) begin
          if (!data_s) begin
            state_n = WAIT_IDLE;
          end else begin
            error_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = cnt + 1'b1;
        if (clk_s && data_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // The transfer timeout overrides anything decided above this cycle.
    if (timed && (cnt == TO_LAST)) begin
      state_n   = IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      done_n    = 1'b0;
      error_n   = 1'b1;
    end
  end

  assign host.tx_ready = (state == IDLE);
  assign host.busy     = (state != IDLE);
  assign host.done     = done_q;
  assign host.error    = error_q;
  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_data_oe   = data_oe_q;

endmodule
